rtc_time_counter: RTL and testbench
===================================

Name: rtc_time_counter

Overview:
- Avalon-MM slave timekeeping core, upstream of the hour/minute display PIO stages.
- Prescales the system clock to a 1 Hz tick and keeps BCD seconds, minutes and hours in 24 h format.
- Compares the current time against a programmable alarm and raises an IRQ.
- The CPU reads TIME and writes the decoded digits into the per-digit 7-segment output ports.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock cycles per 1 s tick (bench overrides to 10).
- PRESCALE_W, 26, prescaler counter width; must satisfy 2^PRESCALE_W >= CLK_FREQ_HZ.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address (zero wait states).
- irq  out  1  level interrupt = alarm_flag & irq_en.
- sec_tick  out  1  one-cycle pulse on each 1 s increment.

Behaviour:
- Register map. Only bits listed are implemented; unlisted bits read 0 and writes to them are ignored.
  - Addr 0 TIME (rw):
    - [21:20] hour tens, [19:16] hour units
    - [14:12] min tens, [11:8] min units
    - [6:4] sec tens, [3:0] sec units
  - Addr 1 ALARM (rw): hour/min fields as TIME; sec bits read 0.
  - Addr 2 CONTROL (rw): bit0 run, bit1 alarm_en, bit2 irq_en.
  - Addr 3 STATUS:
    - bit0 alarm_flag, write-1-to-clear
    - bit1 bad_write, write-1-to-clear
  - Addr 4-7: read 0, writes ignored.
- Write strobe is chipselect & ~write_n; the register updates on the next clk edge.
- Reset values:
  - TIME = 00:00:00, ALARM = 00:00
  - CONTROL = 0, STATUS = 0, prescaler = 0
  - irq = 0, sec_tick = 0
- Prescaler:
  - Counts only while run=1; holds its value while run=0.
  - At CLK_FREQ_HZ-1 it wraps to 0 and sec_tick is asserted for exactly one cycle, registered in the same edge as the time increment.
- Increment chain:
  - sec units 9->0 carries to sec tens; sec tens 5->0 carries to minutes.
  - Minutes follow the same rule; the minute carry increments hours.
  - Hours 23->00. 23:59:59 -> 00:00:00 in one tick.
- TIME write:
  - Accepted only if all digits are legal: sec/min tens <=5, units <=9, hours <=23.
  - Accepted write loads TIME and clears the prescaler to 0.
  - Illegal write leaves TIME unchanged and sets bad_write.
  - Same rules apply to ALARM, except the prescaler is not affected.
- Write vs tick in the same cycle: the TIME write wins, the tick is discarded, and sec_tick is still pulsed.
- Alarm:
  - alarm_flag sets on the edge where a tick produces hh:mm:00 equal to ALARM, with alarm_en=1.
  - A TIME write that lands on the alarm does not trigger it.
- alarm_flag set and W1C in the same cycle: set wins.
- Clearing alarm_en does not clear alarm_flag.
- Reset asserted mid-count returns everything to reset values immediately; no tick after deassertion before a full prescale period.

Optional Feature:
- Macro RTC_12H_EN.
- Defined:
  - CONTROL bit3 = mode12 (rw, reset 0). Internal count stays 24 h.
  - With mode12=1, TIME reads report hours 12,1..11 with bit23 = PM (hours >=12).
  - TIME writes in mode12 take 1..12 plus bit23 and convert to 24 h; hour 0 or >12 is illegal and sets bad_write.
  - ALARM fields are always 24 h.
- Undefined: CONTROL bit3 and TIME bit23 read 0; writes to them are ignored.

Decomposition:
- Package rtc_pkg:
  - register address constants
  - CONTROL/STATUS bit indices
  - TIME field offsets/widths
  - BCD digit limits (9, 5, 23)
- Sub-module bcd_digit_counter:
  - Parameterised max value; inputs inc, load, load_val; outputs digit, carry.
  - Instantiated per digit; hours handled by a dedicated 00-23 wrap check in the top.

Test Plan:
- Reset, CLK_FREQ_HZ=10, write CONTROL=1, run 30 cycles -> TIME=0x000003; sec_tick pulsed 3 times, each 10 cycles apart.
- Write TIME=0x235959, run 10 cycles -> TIME=0x000000 and a single sec_tick.
- Write TIME=0x006000 (min tens 6) -> TIME unchanged, STATUS=0x2; write STATUS=0x2 -> STATUS=0.
- ALARM=0x000700, TIME=0x000659, CONTROL=0x7, one tick -> STATUS bit0=1, irq=1; write STATUS=1 -> irq=0.
- TIME write on the exact cycle the prescaler wraps -> written value kept, prescaler=0, no double increment.
- Assert reset mid-count at TIME=0x120000 -> readdata 0 at all addresses, irq=0, sec_tick=0.

Source files
------------

// File: rtl/rtc_time_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Register map, field layout and BCD hour helpers for
//               rtc_time_counter.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam logic [2:0] c_ADDR_TIME    = 3'd0;
    localparam logic [2:0] c_ADDR_ALARM   = 3'd1;
    localparam logic [2:0] c_ADDR_CONTROL = 3'd2;
    localparam logic [2:0] c_ADDR_STATUS  = 3'd3;

    localparam int c_CTRL_RUN      = 0;
    localparam int c_CTRL_ALARM_EN = 1;
    localparam int c_CTRL_IRQ_EN   = 2;
    localparam int c_CTRL_MODE12   = 3;

    localparam int c_STAT_ALARM     = 0;
    localparam int c_STAT_BAD_WRITE = 1;

    localparam int c_SEC_U_LSB = 0;
    localparam int c_SEC_T_LSB = 4;
    localparam int c_MIN_U_LSB = 8;
    localparam int c_MIN_T_LSB = 12;
    localparam int c_HR_U_LSB  = 16;
    localparam int c_HR_T_LSB  = 20;
    localparam int c_PM_BIT    = 23;

    localparam int c_UNITS_W  = 4;
    localparam int c_TENS_W   = 3;
    localparam int c_HTENS_W  = 2;

    localparam logic [3:0] c_UNITS_MAX = 4'd9;
    localparam logic [2:0] c_TENS_MAX  = 3'd5;
    localparam logic [5:0] c_HOURS_MAX = 6'd23;

    typedef struct packed {
        logic [1:0] tens;
        logic [3:0] units;
    } bcd_hr_t;

    typedef struct packed {
        bcd_hr_t    hr;
        logic [2:0] min_t;
        logic [3:0] min_u;
        logic [2:0] sec_t;
        logic [3:0] sec_u;
    } bcd_time_t;

    function automatic logic [5:0] hr_to_bin(input bcd_hr_t h);
        return 6'(h.tens) * 6'd10 + 6'(h.units);
    endfunction

    function automatic bcd_hr_t bin_to_hr(input logic [4:0] b);
        bcd_hr_t r;
        r.tens  = (b >= 5'd20) ? 2'd2 : (b >= 5'd10) ? 2'd1 : 2'd0;
        r.units = 4'(b - 5'(r.tens) * 5'd10);
        return r;
    endfunction

    function automatic logic hr_legal(input bcd_hr_t h);
        return (h.units <= c_UNITS_MAX) && (hr_to_bin(h) <= c_HOURS_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_time_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : rtc_time_counter_if
// Description : Avalon-MM slave bus plus interrupt and tick outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface rtc_time_counter_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        sec_tick;

    modport slave  (input  address, chipselect, write_n, writedata,
                    output readdata, irq, sec_tick);
    modport master (output address, chipselect, write_n, writedata,
                    input  readdata, irq, sec_tick);
endinterface
`default_nettype wire

// File: rtl/rtc_time_counter_bcd_digit_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_counter
// Description : One BCD digit with wrap at MAX_VAL; load has priority over inc.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 9
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    output logic      [WIDTH-1:0] o_digit,
    output logic      [WIDTH-1:0] o_next,
    output logic                  o_carry
);
    logic [WIDTH-1:0] r_digit_q;
    logic [WIDTH-1:0] w_digit_d;
    logic             w_at_max;

    assign w_at_max = (r_digit_q == WIDTH'(MAX_VAL));

    always_comb begin
        w_digit_d = r_digit_q;
        if (i_load) begin
            w_digit_d = i_load_val;
        end else if (i_inc) begin
            w_digit_d = w_at_max ? '0 : r_digit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_digit_q <= '0;
        else     r_digit_q <= w_digit_d;
    end

    assign o_digit = r_digit_q;
    assign o_next  = w_digit_d;
    assign o_carry = i_inc & w_at_max;
endmodule
`default_nettype wire

// File: rtl/rtc_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : rtc_time_counter
// Description : Avalon-MM BCD real-time clock with alarm IRQ and 1 Hz tick.
//               Define RTC_12H_EN for the 12-hour TIME view (CONTROL bit3).
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int PRESCALE_W  = 26
) (
    input  wire logic         clk,
    input  wire logic         reset,
    rtc_time_counter_if.slave avs
);
    localparam logic [PRESCALE_W-1:0] c_PRESC_LAST = PRESCALE_W'(CLK_FREQ_HZ - 1);
`ifdef RTC_12H_EN
    localparam logic [3:0] c_CTRL_WMASK = 4'hF;
`else
    localparam logic [3:0] c_CTRL_WMASK = ~(4'b1 << c_CTRL_MODE12);
`endif

    logic [PRESCALE_W-1:0] r_presc_q, w_presc_d;
    logic [3:0]            r_ctrl_q, w_ctrl_d;
    bcd_hr_t               r_alarm_hr_q, w_alarm_hr_d;
    logic [6:0]            r_alarm_min_q, w_alarm_min_d;
    logic                  r_alarm_flag_q, w_alarm_flag_d;
    logic                  r_bad_write_q, w_bad_write_d;
    logic                  r_sec_tick_q, w_sec_tick_d;

    logic [31:0] w_wd, w_rdata;
    logic        w_wr, w_wr_time, w_wr_alarm, w_wr_ctrl, w_wr_status;
    logic        w_ss_ok, w_ms_ok, w_hr_ok, w_alarm_ok;
    logic        w_time_load, w_alarm_load, w_bad;
    logic        w_wrap, w_tick, w_alarm_hit, w_hr_wrap, w_hr_load;
    logic        w_su_c, w_st_c, w_mu_c, w_mt_c, w_hu_c, w_ht_c;
    bcd_hr_t     w_wd_hr, w_ld_hr, w_hr_load_val, w_rd_hr;
    logic        w_rd_pm;
    bcd_time_t   w_time, w_next;
    logic        w_unused_ok;

    assign w_wd        = avs.writedata;
    assign w_wr        = avs.chipselect & ~avs.write_n;
    assign w_wr_time   = w_wr & (avs.address == c_ADDR_TIME);
    assign w_wr_alarm  = w_wr & (avs.address == c_ADDR_ALARM);
    assign w_wr_ctrl   = w_wr & (avs.address == c_ADDR_CONTROL);
    assign w_wr_status = w_wr & (avs.address == c_ADDR_STATUS);

    assign w_wd_hr    = bcd_hr_t'(w_wd[c_HR_U_LSB +: 6]);
    assign w_ss_ok    = (w_wd[c_SEC_T_LSB +: c_TENS_W] <= c_TENS_MAX) &&
                        (w_wd[c_SEC_U_LSB +: c_UNITS_W] <= c_UNITS_MAX);
    assign w_ms_ok    = (w_wd[c_MIN_T_LSB +: c_TENS_W] <= c_TENS_MAX) &&
                        (w_wd[c_MIN_U_LSB +: c_UNITS_W] <= c_UNITS_MAX);
    assign w_alarm_ok = w_ms_ok && hr_legal(w_wd_hr);

`ifdef RTC_12H_EN
    logic [5:0] w_wr_h12, w_rd_h24;
    logic [4:0] w_wr_h24, w_rd_h12;
    assign w_wr_h12 = hr_to_bin(w_wd_hr);
    assign w_wr_h24 = ((w_wr_h12 == 6'd12) ? 5'd0 : w_wr_h12[4:0]) +
                      (w_wd[c_PM_BIT] ? 5'd12 : 5'd0);
    assign w_hr_ok  = r_ctrl_q[c_CTRL_MODE12]
                    ? ((w_wd_hr.units <= c_UNITS_MAX) && (w_wr_h12 != 6'd0) && (w_wr_h12 <= 6'd12))
                    : hr_legal(w_wd_hr);
    assign w_ld_hr  = r_ctrl_q[c_CTRL_MODE12] ? bin_to_hr(w_wr_h24) : w_wd_hr;
    // Internal count is 24 h; the 12 h form exists only on the read path.
    assign w_rd_h24 = hr_to_bin(w_time.hr);
    assign w_rd_h12 = (w_rd_h24 == 6'd0)  ? 5'd12 :
                      (w_rd_h24 > 6'd12)  ? 5'(w_rd_h24 - 6'd12) : w_rd_h24[4:0];
    assign w_rd_pm  = r_ctrl_q[c_CTRL_MODE12] && (w_rd_h24 >= 6'd12);
    assign w_rd_hr  = r_ctrl_q[c_CTRL_MODE12] ? bin_to_hr(w_rd_h12) : w_time.hr;
`else
    assign w_hr_ok  = hr_legal(w_wd_hr);
    assign w_ld_hr  = w_wd_hr;
    assign w_rd_pm  = 1'b0;
    assign w_rd_hr  = w_time.hr;
`endif

    assign w_time_load  = w_wr_time & w_ss_ok & w_ms_ok & w_hr_ok;
    assign w_alarm_load = w_wr_alarm & w_alarm_ok;
    assign w_bad        = (w_wr_time & ~(w_ss_ok & w_ms_ok & w_hr_ok)) |
                          (w_wr_alarm & ~w_alarm_ok);

    // A wrap coinciding with an accepted TIME write still pulses sec_tick but does not count.
    assign w_wrap = r_ctrl_q[c_CTRL_RUN] && (r_presc_q == c_PRESC_LAST);
    assign w_tick = w_wrap & ~w_time_load;

    assign w_hr_wrap     = w_mt_c && (w_time.hr == bcd_hr_t'(6'h23));
    assign w_hr_load     = w_time_load | w_hr_wrap;
    assign w_hr_load_val = w_time_load ? w_ld_hr : bcd_hr_t'(6'h00);

    bcd_digit_counter #(.WIDTH(c_UNITS_W), .MAX_VAL(9)) u_sec_u (
        .clk(clk), .rst(reset), .i_inc(w_tick), .i_load(w_time_load),
        .i_load_val(w_wd[c_SEC_U_LSB +: c_UNITS_W]),
        .o_digit(w_time.sec_u), .o_next(w_next.sec_u), .o_carry(w_su_c));
    bcd_digit_counter #(.WIDTH(c_TENS_W), .MAX_VAL(5)) u_sec_t (
        .clk(clk), .rst(reset), .i_inc(w_su_c), .i_load(w_time_load),
        .i_load_val(w_wd[c_SEC_T_LSB +: c_TENS_W]),
        .o_digit(w_time.sec_t), .o_next(w_next.sec_t), .o_carry(w_st_c));
    bcd_digit_counter #(.WIDTH(c_UNITS_W), .MAX_VAL(9)) u_min_u (
        .clk(clk), .rst(reset), .i_inc(w_st_c), .i_load(w_time_load),
        .i_load_val(w_wd[c_MIN_U_LSB +: c_UNITS_W]),
        .o_digit(w_time.min_u), .o_next(w_next.min_u), .o_carry(w_mu_c));
    bcd_digit_counter #(.WIDTH(c_TENS_W), .MAX_VAL(5)) u_min_t (
        .clk(clk), .rst(reset), .i_inc(w_mu_c), .i_load(w_time_load),
        .i_load_val(w_wd[c_MIN_T_LSB +: c_TENS_W]),
        .o_digit(w_time.min_t), .o_next(w_next.min_t), .o_carry(w_mt_c));
    bcd_digit_counter #(.WIDTH(c_UNITS_W), .MAX_VAL(9)) u_hr_u (
        .clk(clk), .rst(reset), .i_inc(w_mt_c & ~w_hr_wrap), .i_load(w_hr_load),
        .i_load_val(w_hr_load_val.units),
        .o_digit(w_time.hr.units), .o_next(w_next.hr.units), .o_carry(w_hu_c));
    bcd_digit_counter #(.WIDTH(c_HTENS_W), .MAX_VAL(2)) u_hr_t (
        .clk(clk), .rst(reset), .i_inc(w_hu_c), .i_load(w_hr_load),
        .i_load_val(w_hr_load_val.tens),
        .o_digit(w_time.hr.tens), .o_next(w_next.hr.tens), .o_carry(w_ht_c));

    assign w_alarm_hit = w_tick && r_ctrl_q[c_CTRL_ALARM_EN] &&
                         (w_next.sec_t == 3'd0) && (w_next.sec_u == 4'd0) &&
                         ({w_next.min_t, w_next.min_u} == r_alarm_min_q) &&
                         (w_next.hr == r_alarm_hr_q);

    always_comb begin
        w_presc_d      = r_presc_q;
        w_ctrl_d       = r_ctrl_q;
        w_alarm_hr_d   = r_alarm_hr_q;
        w_alarm_min_d  = r_alarm_min_q;
        w_alarm_flag_d = r_alarm_flag_q;
        w_bad_write_d  = r_bad_write_q;
        w_sec_tick_d   = w_wrap;

        if (w_time_load)               w_presc_d = '0;
        else if (r_ctrl_q[c_CTRL_RUN]) w_presc_d = w_wrap ? '0 : r_presc_q + 1'b1;

        if (w_wr_ctrl) w_ctrl_d = w_wd[3:0] & c_CTRL_WMASK;

        if (w_alarm_load) begin
            w_alarm_hr_d  = w_wd_hr;
            w_alarm_min_d = {w_wd[c_MIN_T_LSB +: c_TENS_W], w_wd[c_MIN_U_LSB +: c_UNITS_W]};
        end

        if (w_wr_status && w_wd[c_STAT_ALARM])     w_alarm_flag_d = 1'b0;
        if (w_alarm_hit)                           w_alarm_flag_d = 1'b1;
        if (w_wr_status && w_wd[c_STAT_BAD_WRITE]) w_bad_write_d  = 1'b0;
        if (w_bad)                                 w_bad_write_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc_q      <= '0;
            r_ctrl_q       <= '0;
            r_alarm_hr_q   <= '0;
            r_alarm_min_q  <= '0;
            r_alarm_flag_q <= 1'b0;
            r_bad_write_q  <= 1'b0;
            r_sec_tick_q   <= 1'b0;
        end else begin
            r_presc_q      <= w_presc_d;
            r_ctrl_q       <= w_ctrl_d;
            r_alarm_hr_q   <= w_alarm_hr_d;
            r_alarm_min_q  <= w_alarm_min_d;
            r_alarm_flag_q <= w_alarm_flag_d;
            r_bad_write_q  <= w_bad_write_d;
            r_sec_tick_q   <= w_sec_tick_d;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (avs.address)
            c_ADDR_TIME: begin
                w_rdata[c_SEC_U_LSB +: c_UNITS_W] = w_time.sec_u;
                w_rdata[c_SEC_T_LSB +: c_TENS_W]  = w_time.sec_t;
                w_rdata[c_MIN_U_LSB +: c_UNITS_W] = w_time.min_u;
                w_rdata[c_MIN_T_LSB +: c_TENS_W]  = w_time.min_t;
                w_rdata[c_HR_U_LSB +: c_UNITS_W]  = w_rd_hr.units;
                w_rdata[c_HR_T_LSB +: c_HTENS_W]  = w_rd_hr.tens;
                w_rdata[c_PM_BIT]                 = w_rd_pm;
            end
            c_ADDR_ALARM: begin
                w_rdata[c_MIN_U_LSB +: c_UNITS_W] = r_alarm_min_q[3:0];
                w_rdata[c_MIN_T_LSB +: c_TENS_W]  = r_alarm_min_q[6:4];
                w_rdata[c_HR_U_LSB +: c_UNITS_W]  = r_alarm_hr_q.units;
                w_rdata[c_HR_T_LSB +: c_HTENS_W]  = r_alarm_hr_q.tens;
            end
            c_ADDR_CONTROL: w_rdata[3:0] = r_ctrl_q;
            c_ADDR_STATUS: begin
                w_rdata[c_STAT_ALARM]     = r_alarm_flag_q;
                w_rdata[c_STAT_BAD_WRITE] = r_bad_write_q;
            end
            default: w_rdata = '0;
        endcase
    end

    assign avs.readdata = w_rdata;
    assign avs.irq      = r_alarm_flag_q & r_ctrl_q[c_CTRL_IRQ_EN];
    assign avs.sec_tick = r_sec_tick_q;

    assign w_unused_ok = ^{w_wd[31:22], w_wd[15], w_wd[7], w_ht_c};
endmodule
`default_nettype wire

// File: tb/tb_rtc_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_time_counter
// Description : Directed vector table plus wrap/reset corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_time_counter;
`ifdef RTC_12H_EN
    localparam logic [31:0] c_EXP_CTRL_F = 32'hF;
`else
    localparam logic [31:0] c_EXP_CTRL_F = 32'h7;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   tick_cnt;
    longint tick_t [3];

    rtc_time_counter_if avs_if ();

    rtc_time_counter #(.CLK_FREQ_HZ(10), .PRESCALE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .avs   (avs_if)
    );

    typedef struct {
        logic        do_wr;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        int          idle_n;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        int          exp_ticks;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (avs_if.sec_tick === 1'b1) begin
            if (tick_cnt < 3) tick_t[tick_cnt] = $time;
            tick_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_if.address    = a;
        avs_if.writedata  = d;
        avs_if.chipselect = 1'b1;
        avs_if.write_n    = 1'b0;
        @(negedge clk);
        avs_if.chipselect = 1'b0;
        avs_if.write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_if.address = a;
        #1;
        d = avs_if.readdata;
    endtask

    initial begin
        logic [31:0] rd;
        int          t0;

        n_checks = 0;
        n_errors = 0;
        tick_cnt = 0;
        reset = 1'b1;
        avs_if.address    = '0;
        avs_if.chipselect = 1'b0;
        avs_if.write_n    = 1'b1;
        avs_if.writedata  = '0;
        idle(2);
        reset = 1'b0;
        idle(1);

        for (int a = 0; a < 4; a++) begin
            bus_read(3'(a), rd);
            chk($sformatf("reset_reg%0d", a), rd, 32'h0);
        end
        chk("reset_irq", {31'b0, avs_if.irq}, 32'h0);
        chk("reset_tick", {31'b0, avs_if.sec_tick}, 32'h0);

        //               wr    waddr  wdata         idle rdaddr exp           ticks irq
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0001, 30, 3'd0, 32'h0000_0003, 3, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h0023_5959, 10, 3'd0, 32'h0000_0000, 1, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_6000,  0, 3'd0, 32'h0000_0000, 0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'h0,          0, 3'd3, 32'h0000_0002, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd3, 32'h0000_0002,  0, 3'd3, 32'h0000_0000, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0000,  0, 3'd2, 32'h0000_0000, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 32'h0000_0759,  0, 3'd1, 32'h0000_0700, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_0659,  0, 3'd0, 32'h0000_0659, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0007, 10, 3'd3, 32'h0000_0001, 1, 1'b1});
        vecs.push_back('{1'b1, 3'd3, 32'h0000_0001,  0, 3'd3, 32'h0000_0000, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 32'h0024_0000,  0, 3'd1, 32'h0000_0700, 0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'h0,          0, 3'd3, 32'h0000_0002, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd3, 32'h0000_0002,  0, 3'd3, 32'h0000_0000, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_0700,  0, 3'd3, 32'h0000_0000, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_0959, 10, 3'd0, 32'h0000_1000, 1, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h0009_5959, 10, 3'd0, 32'h0010_0000, 1, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h0019_5959, 10, 3'd0, 32'h0020_0000, 1, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_000F,  0, 3'd2, c_EXP_CTRL_F,  0, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0007,  0, 3'd2, 32'h0000_0007, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd5, 32'hFFFF_FFFF,  0, 3'd5, 32'h0000_0000, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h0024_0000,  0, 3'd0, 32'h0020_0000, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd3, 32'h0000_0002,  0, 3'd3, 32'h0000_0000, 0, 1'b0});

        foreach (vecs[i]) begin
            t0 = tick_cnt;
            if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdata);
            idle(vecs[i].idle_n);
            bus_read(vecs[i].raddr, rd);
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_ticks", i), 32'(tick_cnt - t0), 32'(vecs[i].exp_ticks));
            chk($sformatf("vec%0d_irq", i), {31'b0, avs_if.irq}, {31'b0, vecs[i].exp_irq});
        end

        chk("tick_gap_01", 32'(tick_t[1] - tick_t[0]), 32'd100);
        chk("tick_gap_12", 32'(tick_t[2] - tick_t[1]), 32'd100);

        // TIME write landing on the prescaler wrap edge
        bus_write(3'd0, 32'h0000_0100);
        idle(9);
        t0 = tick_cnt;
        bus_write(3'd0, 32'h0000_1234);
        bus_read(3'd0, rd);
        chk("wrap_wr_time", rd, 32'h0000_1234);
        chk("wrap_wr_tick", 32'(tick_cnt - t0), 32'd1);
        t0 = tick_cnt;
        idle(9);
        bus_read(3'd0, rd);
        chk("wrap_presc_hold", rd, 32'h0000_1234);
        chk("wrap_no_tick", 32'(tick_cnt - t0), 32'd0);
        idle(1);
        bus_read(3'd0, rd);
        chk("wrap_next_tick", rd, 32'h0000_1235);

        // Alarm at 12:00, then reset mid-count
        bus_write(3'd1, 32'h0012_0000);
        bus_write(3'd0, 32'h0011_5959);
        idle(10);
        bus_read(3'd0, rd);
        chk("noon_time", rd, 32'h0012_0000);
        chk("noon_irq", {31'b0, avs_if.irq}, 32'h1);
        idle(3);
        reset = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            chk($sformatf("midrst_reg%0d", a), rd, 32'h0);
        end
        chk("midrst_irq", {31'b0, avs_if.irq}, 32'h0);
        chk("midrst_tick", {31'b0, avs_if.sec_tick}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        t0 = tick_cnt;
        idle(12);
        chk("post_rst_idle_ticks", 32'(tick_cnt - t0), 32'd0);
        bus_write(3'd2, 32'h0000_0001);
        t0 = tick_cnt;
        idle(9);
        chk("post_rst_early_ticks", 32'(tick_cnt - t0), 32'd0);
        idle(1);
        chk("post_rst_first_tick", 32'(tick_cnt - t0), 32'd1);
        bus_read(3'd0, rd);
        chk("post_rst_time", rd, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
